// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared i2c instruction codes, arbiter state encodings and the
// round-robin tie-break helper.
package i2c_bus_arbiter_pkg;

    localparam int unsigned INST_W = 2;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        I2C_START = 2'd0,
        I2C_STOP  = 2'd1,
        I2C_READ  = 2'd2,
        I2C_WRITE = 2'd3
    } i2c_inst_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_FORCE_STOP = 2'd2,
        ST_FORCE_WAIT = 2'd3
    } arb_state_e;

    // Winner among eligible clients: on a tie, the one that did not win last time.
    function automatic logic pick_client(input logic elig0, input logic elig1, input logic last);
        return (elig0 && elig1) ? !last : elig1;
    endfunction

endpackage

// File: rtl/i2c_idle_timer.sv
// Clearable idle counter; o_tc_c flags that TIMEOUT_CYCLES-1 has been reached.
module i2c_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd2700000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at the terminal count so it never wraps while idling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (r_count != TC_VAL) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_count == TC_VAL);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c core between two clients, with an
// idle-grant watchdog that reclaims the bus by issuing STOP itself.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 32'd2700000,
    parameter logic [INST_W-1:0] INST_STOP      = INST_W'(I2C_STOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic [INST_W-1:0] inst0,
    input  logic [INST_W-1:0] inst1,
    input  logic              en0,
    input  logic              en1,
    input  logic [BYTE_W-1:0] tx0,
    input  logic [BYTE_W-1:0] tx1,
    output logic              done0,
    output logic              done1,
    output logic [BYTE_W-1:0] rxByte,
    output logic              abort0,
    output logic              abort1,
    output logic [INST_W-1:0] i2cInstruction,
    output logic              i2cEnable,
    output logic [BYTE_W-1:0] i2cByteToSend,
    input  logic [BYTE_W-1:0] i2cByteReceived,
    input  logic              i2cComplete
);

    arb_state_e r_state;
    logic       r_last;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_abort0;
    logic       r_abort1;
    logic       r_blocked0;
    logic       r_blocked1;

    logic              w_own_req;
    logic              w_own_en;
    logic [INST_W-1:0] w_own_inst;
    logic [BYTE_W-1:0] w_own_tx;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_pick;
    logic              w_quiet;
    logic              w_release;
    logic              w_tc;
    logic              w_expire;
    logic              w_tmr_clr;

    // Owner is always the last client granted.
    always_comb begin
        w_own_req  = r_last ? req1  : req0;
        w_own_en   = r_last ? en1   : en0;
        w_own_inst = r_last ? inst1 : inst0;
        w_own_tx   = r_last ? tx1   : tx0;
    end

    assign w_elig0   = req0 && !r_blocked0;
    assign w_elig1   = req1 && !r_blocked1;
    assign w_pick    = pick_client(w_elig0, w_elig1, r_last);
    assign w_quiet   = !w_own_en && !i2cComplete;
    assign w_release = !w_own_req && w_quiet;
    assign w_tmr_clr = (r_state != ST_GRANT) || !w_quiet;
    assign w_expire  = (r_state == ST_GRANT) && w_quiet && w_tc;

    i2c_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_tmr_clr),
        .o_tc_c(w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_abort0   <= 1'b0;
            r_abort1   <= 1'b0;
            r_blocked0 <= 1'b0;
            r_blocked1 <= 1'b0;
        end else begin
            r_abort0 <= 1'b0;
            r_abort1 <= 1'b0;
            if (!req0) r_blocked0 <= 1'b0;
            if (!req1) r_blocked1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_elig0 || w_elig1) begin
                        r_state <= ST_GRANT;
                        r_last  <= w_pick;
                        r_gnt0  <= !w_pick;
                        r_gnt1  <= w_pick;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                    end else if (w_expire) begin
                        // Hung owner: revoke, flag it, and keep it out until it drops req.
                        r_state <= ST_FORCE_STOP;
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        if (r_last) begin
                            r_abort1   <= 1'b1;
                            r_blocked1 <= 1'b1;
                        end else begin
                            r_abort0   <= 1'b1;
                            r_blocked0 <= 1'b1;
                        end
                    end
                end
                ST_FORCE_STOP: begin
                    if (i2cComplete) r_state <= ST_FORCE_WAIT;
                end
                ST_FORCE_WAIT: begin
                    if (!i2cComplete) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Core-facing mux follows the owner combinationally so handshakes see no extra latency.
    always_comb begin
        i2cInstruction = '0;
        i2cEnable      = 1'b0;
        i2cByteToSend  = '0;
        done0          = 1'b0;
        done1          = 1'b0;
        case (r_state)
            ST_GRANT: begin
                i2cInstruction = w_own_inst;
                i2cEnable      = w_own_en;
                i2cByteToSend  = w_own_tx;
                done0          = i2cComplete && !r_last;
                done1          = i2cComplete && r_last;
            end
            ST_FORCE_STOP: begin
                i2cInstruction = INST_STOP;
                i2cEnable      = 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt0   = r_gnt0;
    assign gnt1   = r_gnt1;
    assign abort0 = r_abort0;
    assign abort1 = r_abort1;
    assign rxByte = i2cByteReceived;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized closed-loop bench: clients, core responder and reference model
// live here; a negedge monitor pops expected outputs from a scoreboard queue.
module tb_i2c_bus_arbiter;

    localparam int unsigned TMO  = 16;
    localparam int          NCYC = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] c_req;
    logic [1:0] c_en;
    logic [1:0] c_inst [2];
    logic [7:0] c_tx   [2];
    logic [7:0] rxb;
    logic       cmp;

    logic       gnt0, gnt1, done0, done1, abort0, abort1, i2cEnable;
    logic [1:0] i2cInstruction;
    logic [7:0] i2cByteToSend, rxByte;

    i2c_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (c_req[0]),
        .req1           (c_req[1]),
        .gnt0           (gnt0),
        .gnt1           (gnt1),
        .inst0          (c_inst[0]),
        .inst1          (c_inst[1]),
        .en0            (c_en[0]),
        .en1            (c_en[1]),
        .tx0            (c_tx[0]),
        .tx1            (c_tx[1]),
        .done0          (done0),
        .done1          (done1),
        .rxByte         (rxByte),
        .abort0         (abort0),
        .abort1         (abort1),
        .i2cInstruction (i2cInstruction),
        .i2cEnable      (i2cEnable),
        .i2cByteToSend  (i2cByteToSend),
        .i2cByteReceived(rxb),
        .i2cComplete    (cmp)
    );

    typedef struct packed {
        logic [3:0]  grant;   // gnt0, gnt1, abort0, abort1
        logic [1:0]  done;    // done0, done1
        logic [10:0] core;    // enable, instruction, byte
        logic [7:0]  rx;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: who owns the bus, whether a reclaim is in progress, idle streak.
    int       m_owner;     // -1 = nobody
    int       m_reclaim;   // 0 none, 1 STOP outstanding, 2 waiting for complete to drop
    int       m_idle_run;
    int       m_last;
    bit [1:0] m_kicked;
    bit [1:0] m_abort;

    function automatic void model_reset();
        m_owner    = -1;
        m_reclaim  = 0;
        m_idle_run = 0;
        m_last     = 1;
        m_kicked   = '0;
        m_abort    = '0;
    endfunction

    function automatic exp_t model_expect();
        exp_t e;
        e.grant = {m_owner == 0, m_owner == 1, m_abort[0], m_abort[1]};
        e.done  = {(m_owner == 0) && cmp, (m_owner == 1) && cmp};
        if (m_owner >= 0)       e.core = {c_en[m_owner], c_inst[m_owner], c_tx[m_owner]};
        else if (m_reclaim == 1) e.core = {1'b1, 2'd1, 8'd0};
        else                     e.core = '0;
        e.rx = rxb;
        return e;
    endfunction

    function automatic void model_advance();
        bit [1:0] ab;
        bit       can0, can1;
        int       o;
        ab = '0;
        o  = m_owner;
        if (o >= 0) begin
            if (!c_req[o] && !c_en[o] && !cmp) begin
                m_owner = -1;
            end else if (!c_en[o] && !cmp) begin
                m_idle_run++;
                if (m_idle_run == TMO) begin
                    m_owner     = -1;
                    m_reclaim   = 1;
                    ab[o]       = 1'b1;
                    m_kicked[o] = 1'b1;
                end
            end else begin
                m_idle_run = 0;
            end
        end else if (m_reclaim == 1) begin
            if (cmp) m_reclaim = 2;
        end else if (m_reclaim == 2) begin
            if (!cmp) m_reclaim = 0;
        end else begin
            can0 = c_req[0] && !m_kicked[0];
            can1 = c_req[1] && !m_kicked[1];
            if (can0 || can1) begin
                m_owner    = (can0 && can1) ? (1 - m_last) : (can0 ? 0 : 1);
                m_last     = m_owner;
                m_idle_run = 0;
            end
        end
        for (int i = 0; i < 2; i++) if (!c_req[i]) m_kicked[i] = 1'b0;
        m_abort = ab;
    endfunction

    // Core responder: complete 3 clocks after enable, drops one clock after enable drops.
    int   core_cnt;
    logic core_en_prev;

    task automatic core_step();
        if (core_en_prev) begin
            if (core_cnt < 3) core_cnt++;
            cmp = (core_cnt >= 3);
        end else begin
            core_cnt = 0;
            cmp      = 1'b0;
        end
    endtask

    // Client behaviour: a few operations per request; some requests hang.
    int c_ops   [2];
    int c_phase [2];
    int c_hold  [2];
    bit c_hang  [2];

    task automatic clients_reset(input bit tie);
        for (int i = 0; i < 2; i++) begin
            c_req[i]   = tie;
            c_en[i]    = 1'b0;
            c_inst[i]  = 2'd0;
            c_tx[i]    = 8'd0;
            c_ops[i]   = 2;
            c_phase[i] = 0;
            c_hold[i]  = 0;
            c_hang[i]  = 1'b0;
        end
    endtask

    task automatic client_step(input int i);
        if (m_owner == i) begin
            if (c_hang[i]) begin
                c_en[i] = 1'b0;
            end else begin
                case (c_phase[i])
                    0: begin
                        if (c_ops[i] == 0) begin
                            c_req[i] = 1'b0;
                            c_en[i]  = 1'b0;
                        end else if ($urandom_range(0, 2) == 0) begin
                            c_en[i] = 1'b0;
                        end else begin
                            c_en[i]    = 1'b1;
                            c_inst[i]  = 2'($urandom);
                            c_tx[i]    = 8'($urandom);
                            c_phase[i] = 1;
                            if (c_ops[i] == 1 && $urandom_range(0, 2) == 0) c_req[i] = 1'b0;
                        end
                    end
                    1: if (cmp) begin
                        c_en[i]    = 1'b0;
                        c_phase[i] = 2;
                    end
                    default: if (!cmp) begin
                        c_ops[i]--;
                        c_phase[i] = 0;
                    end
                endcase
            end
        end else if (!c_req[i]) begin
            c_en[i]   = ($urandom_range(0, 3) == 0);
            c_inst[i] = 2'($urandom);
            c_tx[i]   = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                c_req[i]   = 1'b1;
                c_en[i]    = 1'b0;
                c_ops[i]   = $urandom_range(1, 3);
                c_hang[i]  = ($urandom_range(0, 5) == 0);
                c_phase[i] = 0;
                c_hold[i]  = 0;
            end
        end else begin
            c_en[i] = ($urandom_range(0, 3) == 0);
            if (m_kicked[i]) begin
                c_hold[i]++;
                if (c_hold[i] > 5) c_req[i] = 1'b0;
            end
        end
    endtask

    task automatic push_and_advance();
        exp_t e;
        e = model_expect();
        exp_q.push_back(e);
        core_en_prev = e.core[10];
        model_advance();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("grant_abort", 32'({gnt0, gnt1, abort0, abort1}), 32'(mon_e.grant));
            check("done", 32'({done0, done1}), 32'(mon_e.done));
            check("core_bus", 32'({i2cEnable, i2cInstruction, i2cByteToSend}), 32'(mon_e.core));
            check("rx_byte", 32'(rxByte), 32'(mon_e.rx));
        end
    end

    bit did_rst;

    initial begin
        did_rst      = 1'b0;
        reset        = 1'b1;
        cmp          = 1'b0;
        rxb          = 8'h3C;
        core_cnt     = 0;
        core_en_prev = 1'b0;
        clients_reset(1'b0);
        model_reset();
        #2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant", 32'({gnt0, gnt1, abort0, abort1}), 32'd0);
        check("reset_done", 32'({done0, done1}), 32'd0);
        check("reset_core", 32'({i2cEnable, i2cInstruction, i2cByteToSend}), 32'd0);
        check("reset_rx", 32'(rxByte), 32'h3C);
        reset = 1'b0;
        clients_reset(1'b1);
        rxb = 8'($urandom);
        #1 push_and_advance();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            core_step();
            if (!did_rst && cyc > 200 && m_reclaim == 1) begin
                reset = 1'b1;
                #1;
                check("async_reset_enable", 32'(i2cEnable), 32'd0);
                check("async_reset_grant", 32'({gnt0, gnt1, abort0, abort1}), 32'd0);
                @(posedge clk);
                #1;
                reset        = 1'b0;
                did_rst      = 1'b1;
                core_cnt     = 0;
                core_en_prev = 1'b0;
                cmp          = 1'b0;
                model_reset();
                clients_reset(1'b1);
            end else begin
                client_step(0);
                client_step(1);
            end
            rxb = 8'($urandom);
            #1 push_and_advance();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("reset_in_force_stop_reached", 32'(did_rst), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
